// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: streams a program image into memory with the CPU held,
// optionally zero-fills the remainder, then releases the CPU and passes its memory port through.
module cpu_boot_ctrl #(
  parameter bit          ZERO_FILL      = 1'b1,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] load_len,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] cpu_address,
  input  logic [7:0] cpu_to_memory,
  input  logic       cpu_write,
  output logic [7:0] mem_address,
  output logic [7:0] mem_to_memory,
  output logic       mem_write,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 9;
  localparam int unsigned RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [LW-1:0] MAX_LEN  = LW'(256);
  localparam logic [AW-1:0] LAST_ADR = AW'(255);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_FILL    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] count_q, count_d;
  logic [RW-1:0] rel_q, rel_d;
  logic          hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          handshake;

  // State and registered memory-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      len_q   <= '0;
      count_q <= '0;
      rel_q   <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      count_q <= count_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s_ready   = (state_q == ST_LOAD) && (count_q < len_q);
  assign handshake = s_valid && s_ready;

  // Next-state and next register values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    len_d   = len_q;
    count_d = count_q;
    rel_d   = '0;
    hold_d  = hold_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          len_d   = (load_len > MAX_LEN) ? MAX_LEN : load_len;
          ptr_d   = '0;
          count_d = '0;
          hold_d  = 1'b1;
          if (len_d == '0) state_d = ZERO_FILL ? ST_FILL : ST_RELEASE;
          else             state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          addr_d  = ptr_q;
          wdata_d = s_data;
          wr_d    = 1'b1;
          ptr_d   = AW'(ptr_q + 1'b1);
          count_d = LW'(count_q + 1'b1);
        end
        // Leave on the edge of the last accepted byte so fill follows without a gap
        if (count_d == len_q)
          state_d = (ZERO_FILL && (len_q != MAX_LEN)) ? ST_FILL : ST_RELEASE;
      end
      ST_FILL: begin
        addr_d  = ptr_q;
        wdata_d = '0;
        wr_d    = 1'b1;
        ptr_d   = AW'(ptr_q + 1'b1);
        if (ptr_q == LAST_ADR) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Hold countdown starts only once the final registered write has drained
        if (wr_q) begin
          rel_d = rel_q;
        end else if (rel_q == REL_LAST) begin
          state_d = ST_RUN;
          hold_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rel_d = RW'(rel_q + 1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_FILL) || (state_d == ST_RELEASE);
  end

  // In RUN the CPU owns the memory port with zero latency
  assign mem_address   = (state_q == ST_RUN) ? cpu_address   : addr_q;
  assign mem_to_memory = (state_q == ST_RUN) ? cpu_to_memory : wdata_q;
  assign mem_write     = (state_q == ST_RUN) ? cpu_write     : wr_q;

  assign cpu_hold = hold_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Bench for cpu_boot_ctrl: two instances (zero-fill on/off) share stimulus and are
// checked every cycle against a transaction-level model of the boot sequence.
module tb_cpu_boot_ctrl;

  localparam int unsigned RC = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [8:0] load_len;
  logic [7:0] s_data;
  logic       s_valid;
  logic [7:0] cpu_address;
  logic [7:0] cpu_to_memory;
  logic       cpu_write;

  logic       s_ready       [2];
  logic [7:0] mem_address   [2];
  logic [7:0] mem_to_memory [2];
  logic       mem_write     [2];
  logic       cpu_hold      [2];
  logic       busy          [2];
  logic       done          [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Model: instance 0 zero-fills, instance 1 does not
  bit       m_sess  [2];
  bit       m_run   [2];
  bit       m_done  [2];
  bit       m_cv    [2];
  logic [7:0] m_ca  [2];
  logic [7:0] m_cd  [2];
  int       m_len   [2];
  int       m_acc   [2];
  int       m_wsch  [2];
  int       m_tot   [2];
  int       m_quiet [2];

  int lens [7] = '{0, 255, 256, 300, 1, 17, 128};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_boot_ctrl #(.ZERO_FILL(g == 0), .RELEASE_CYCLES(RC)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .load_len      (load_len),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready[g]),
      .cpu_address   (cpu_address),
      .cpu_to_memory (cpu_to_memory),
      .cpu_write     (cpu_write),
      .mem_address   (mem_address[g]),
      .mem_to_memory (mem_to_memory[g]),
      .mem_write     (mem_write[g]),
      .cpu_hold      (cpu_hold[g]),
      .busy          (busy[g]),
      .done          (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sess[i] = 0; m_run[i] = 0; m_done[i] = 0; m_cv[i] = 0;
      m_ca[i] = '0; m_cd[i] = '0;
      m_len[i] = 0; m_acc[i] = 0; m_wsch[i] = 0; m_tot[i] = 0; m_quiet[i] = 0;
    end
  endtask

  // One cycle: check outputs at the negedge, drive next inputs, advance the model
  task automatic step(input logic st, input logic [8:0] ll, input logic sv, input logic [7:0] sd,
                      input logic [7:0] ca, input logic [7:0] cd, input logic cw);
    for (int i = 0; i < 2; i++) begin
      if (m_sess[i] && (m_wsch[i] == m_tot[i]) && !m_cv[i]) begin
        m_quiet[i]++;
        if (m_quiet[i] == RC + 1) begin
          m_sess[i] = 0; m_run[i] = 1; m_done[i] = 1;
        end
      end
      if (m_run[i]) begin
        chk("run_hold", i, cpu_hold[i], 0);
        chk("run_busy", i, busy[i], 0);
        chk("run_done", i, done[i], m_done[i]);
        chk("run_ready", i, s_ready[i], 0);
        chk("run_addr", i, mem_address[i], cpu_address);
        chk("run_data", i, mem_to_memory[i], cpu_to_memory);
        chk("run_wr", i, mem_write[i], cpu_write);
      end else if (m_sess[i]) begin
        chk("boot_hold", i, cpu_hold[i], 1);
        chk("boot_busy", i, busy[i], 1);
        chk("boot_done", i, done[i], 0);
        chk("boot_ready", i, s_ready[i], m_acc[i] < m_len[i]);
        chk("boot_wr", i, mem_write[i], m_cv[i]);
        if (m_cv[i]) begin
          chk("boot_addr", i, mem_address[i], m_ca[i]);
          chk("boot_data", i, mem_to_memory[i], m_cd[i]);
        end
      end else begin
        chk("idle_hold", i, cpu_hold[i], 1);
        chk("idle_busy", i, busy[i], 0);
        chk("idle_done", i, done[i], 0);
        chk("idle_ready", i, s_ready[i], 0);
        chk("idle_wr", i, mem_write[i], 0);
        chk("idle_addr", i, mem_address[i], 0);
        chk("idle_data", i, mem_to_memory[i], 0);
      end
    end

    start = st; load_len = ll; s_valid = sv; s_data = sd;
    cpu_address = ca; cpu_to_memory = cd; cpu_write = cw;

    for (int i = 0; i < 2; i++) begin
      bit nv;
      logic [7:0] na, nd;
      nv = 0; na = '0; nd = '0;
      m_done[i] = 0;
      if (reset) begin
        if (st && !m_sess[i]) begin
          m_sess[i] = 1; m_run[i] = 0;
          m_len[i]  = (ll > 9'd256) ? 256 : int'(ll);
          m_acc[i]  = 0; m_wsch[i] = 0; m_quiet[i] = 0;
          m_tot[i]  = (i == 0 && m_len[i] < 256) ? 256 : m_len[i];
        end else if (m_sess[i]) begin
          if (sv && m_acc[i] < m_len[i]) begin
            nv = 1; na = 8'(m_acc[i]); nd = sd;
            m_acc[i]++; m_wsch[i]++;
          end else if (i == 0 && m_acc[i] == m_len[i] && m_wsch[i] < m_tot[i]) begin
            nv = 1; na = 8'(m_wsch[i]); nd = 8'h00;
            m_wsch[i]++;
          end
        end
      end
      m_cv[i] = nv; m_ca[i] = na; m_cd[i] = nd;
    end
    @(negedge clk);
  endtask

  task automatic step_rand();
    step(1'b0, 9'd0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_run(input int budget);
    int k;
    k = 0;
    while (k < budget && !(m_run[0] && m_run[1])) begin
      step_rand();
      k++;
    end
    chk("run_reached", 0, cpu_hold[0], 0);
    chk("run_reached", 1, cpu_hold[1], 0);
  endtask

  // Reset asserted between clock edges; outputs must react without a clock
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("ar_hold", i, cpu_hold[i], 1);
      chk("ar_wr", i, mem_write[i], 0);
      chk("ar_ready", i, s_ready[i], 0);
      chk("ar_busy", i, busy[i], 0);
      chk("ar_done", i, done[i], 0);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; load_len = '0; s_data = '0; s_valid = 1'b0;
    cpu_address = '0; cpu_to_memory = '0; cpu_write = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (3) step(1'b0, 9'd0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b1);
    reset = 1'b1;
    repeat (2) step(1'b0, 9'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    // Three back-to-back bytes, fill, release, done
    step(1'b1, 9'd3, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b0, 9'd0, 1'b1, 8'hA9, 8'h00, 8'h00, 1'b0);
    step(1'b0, 9'd0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
    step(1'b0, 9'd0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0);
    wait_run(600);

    // CPU pass-through in RUN
    step(1'b0, 9'd0, 1'b0, 8'h00, 8'h10, 8'h55, 1'b1);
    repeat (8) step_rand();

    // Restart from RUN with CPU writing; toggling s_valid; second start ignored
    step(1'b1, 9'd4, 1'b0, 8'h00, 8'h10, 8'h55, 1'b1);
    for (int k = 0; k < 10; k++)
      step(k == 3, 9'd50, 1'(k % 2 == 0), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    wait_run(600);

    // Randomized loads including zero, full and over-length requests
    foreach (lens[j]) begin
      step(1'b1, 9'(lens[j]), 1'b0, 8'h00, 8'($urandom), 8'($urandom), 1'b1);
      wait_run(2000);
      repeat (3) step_rand();
    end

    // Over-length load abandoned by an asynchronous reset at byte 100
    step(1'b1, 9'd300, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 400 && m_acc[1] < 100; k++)
      step(1'b0, 9'd0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    async_reset();
    repeat (10) step(1'b0, 9'd0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
